// File: rtl/fust_s_issue_wakeup_pkg.sv
// ============================================================================
// Module      : fust_s_issue_wakeup_pkg
// Description : Shared types for the scalar FU status table and issue port.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package fust_s_issue_wakeup_pkg;

    localparam int NUM_FU = 3;
    localparam int REG_W  = 5;
    localparam int FU_S_W = 2;
    localparam int PTR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    typedef logic [REG_W-1:0]  regbits_t;
    typedef logic [FU_S_W-1:0] fu_sbits_t;

    localparam fu_sbits_t T_NONE = 2'b11;

    typedef enum logic [FU_S_W-1:0] {
        FU_S_ALU    = 2'd0,
        FU_S_LD_ST  = 2'd1,
        FU_S_BRANCH = 2'd2
    } fu_scalar_t;

    typedef struct packed {
        logic      busy;
        logic      issued;
        regbits_t  r;
        regbits_t  r1;
        regbits_t  r2;
        fu_sbits_t t1;
        fu_sbits_t t2;
    } fust_s_row_t;

    typedef fust_s_row_t fust_s_t [NUM_FU];

    typedef struct packed {
        fu_sbits_t fu;
        regbits_t  rd;
        regbits_t  rs1;
        regbits_t  rs2;
    } iss_pkt_t;

    localparam fust_s_row_t ROW_RESET = '{
        busy: 1'b0, issued: 1'b0, r: '0, r1: '0, r2: '0, t1: T_NONE, t2: T_NONE
    };

    // A tag naming the completing FU is already satisfied.
    function automatic fu_sbits_t wake_tag(input fu_sbits_t t, input logic wb_hit,
                                           input fu_sbits_t wb_fu);
        return (wb_hit && (t == wb_fu)) ? T_NONE : t;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fust_s_issue_wakeup_rr_arbiter.sv
// ============================================================================
// Module      : fust_rr_arbiter
// Description : Rotating-priority picker; first request at or after i_ptr wins.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fust_rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [PTR_W-1:0] o_grant,
    output logic             o_gnt_valid
);

    logic [PTR_W:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest request is written last.
    always_comb begin
        o_grant     = '0;
        o_gnt_valid = 1'b0;
        w_idx       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = {1'b0, i_ptr} + (PTR_W + 1)'(k);
            if (w_idx >= (PTR_W + 1)'(N)) begin
                w_idx = w_idx - (PTR_W + 1)'(N);
            end
            if (i_req[w_idx[PTR_W-1:0]]) begin
                o_grant     = w_idx[PTR_W-1:0];
                o_gnt_valid = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fust_s_issue_wakeup.sv
// ============================================================================
// Module      : fust_s_issue_wakeup
// Description : Scalar FU status table: issue selection and writeback wakeup.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fust_s_issue_wakeup
    import fust_s_issue_wakeup_pkg::*;
(
    input  logic              CLK,
    input  logic              nRST,
    input  logic              disp_valid,
    input  logic [FU_S_W-1:0] disp_fu,
    input  logic [REG_W-1:0]  disp_rd,
    input  logic [REG_W-1:0]  disp_rs1,
    input  logic [REG_W-1:0]  disp_rs2,
    input  logic [FU_S_W-1:0] disp_t1,
    input  logic [FU_S_W-1:0] disp_t2,
    output logic [NUM_FU-1:0] disp_ready,
    output logic              iss_valid,
    input  logic              iss_ready,
    output logic [FU_S_W-1:0] iss_fu,
    output logic [REG_W-1:0]  iss_rd,
    output logic [REG_W-1:0]  iss_rs1,
    output logic [REG_W-1:0]  iss_rs2,
    input  logic              wb_valid,
    input  logic [FU_S_W-1:0] wb_fu,
    output logic [NUM_FU-1:0] busy_o,
    output logic              err
);

    fust_s_t          r_tbl;
    logic [PTR_W-1:0] r_ptr;
    logic             r_iss_valid;
    iss_pkt_t         r_pkt;
    logic             r_err;

    logic [NUM_FU-1:0] w_busy;
    logic [NUM_FU-1:0] w_issued;
    logic [NUM_FU-1:0] w_rdy;
    logic [NUM_FU-1:0] w_disp_sel;
    logic [NUM_FU-1:0] w_wb_sel;
    logic              w_disp_ok;
    logic              w_wb_ok;
    logic              w_disp_err;
    logic              w_wb_err;
    logic              w_load;
    logic              w_take;
    logic              w_gnt_valid;
    logic [PTR_W-1:0]  w_grant;

    generate
        for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_row
            assign w_busy[gi]     = r_tbl[gi].busy;
            assign w_issued[gi]   = r_tbl[gi].issued;
            assign w_rdy[gi]      = r_tbl[gi].busy && !r_tbl[gi].issued &&
                                    (r_tbl[gi].t1 == T_NONE) && (r_tbl[gi].t2 == T_NONE);
            assign w_disp_sel[gi] = (disp_fu == FU_S_W'(gi));
            assign w_wb_sel[gi]   = (wb_fu == FU_S_W'(gi));
        end
    endgenerate

    // Out-of-range FU indices select no row, so they fall into the error paths.
    assign w_disp_ok  = disp_valid && |(w_disp_sel & ~w_busy);
    assign w_wb_ok    = wb_valid && |(w_wb_sel & w_busy & w_issued);
    assign w_disp_err = disp_valid && !w_disp_ok && !(wb_valid && (wb_fu == disp_fu));
    assign w_wb_err   = wb_valid && !w_wb_ok;
    assign w_load     = !r_iss_valid || iss_ready;
    assign w_take     = w_load && w_gnt_valid;

    fust_rr_arbiter #(
        .N     (NUM_FU),
        .PTR_W (PTR_W)
    ) u_arb (
        .i_req       (w_rdy),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_gnt_valid (w_gnt_valid)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < NUM_FU; i++) begin
                r_tbl[i] <= ROW_RESET;
            end
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (w_disp_ok && w_disp_sel[i]) begin
                    r_tbl[i].busy   <= 1'b1;
                    r_tbl[i].issued <= 1'b0;
                    r_tbl[i].r      <= disp_rd;
                    r_tbl[i].r1     <= disp_rs1;
                    r_tbl[i].r2     <= disp_rs2;
                    r_tbl[i].t1     <= wake_tag(disp_t1, w_wb_ok, wb_fu);
                    r_tbl[i].t2     <= wake_tag(disp_t2, w_wb_ok, wb_fu);
                end else if (w_wb_ok && w_wb_sel[i]) begin
                    r_tbl[i].busy   <= 1'b0;
                    r_tbl[i].issued <= 1'b0;
                end else begin
                    if (w_take && (w_grant == PTR_W'(i))) begin
                        r_tbl[i].issued <= 1'b1;
                    end
                    if (w_wb_ok && r_tbl[i].busy) begin
                        r_tbl[i].t1 <= wake_tag(r_tbl[i].t1, 1'b1, wb_fu);
                        r_tbl[i].t2 <= wake_tag(r_tbl[i].t2, 1'b1, wb_fu);
                    end
                end
            end
        end
    end

    // Issue register: refills whenever it is empty or its packet is consumed.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_iss_valid <= 1'b0;
            r_pkt       <= '0;
            r_ptr       <= '0;
        end else if (w_load) begin
            r_iss_valid <= w_gnt_valid;
            if (w_gnt_valid) begin
                r_pkt.fu  <= FU_S_W'(w_grant);
                r_pkt.rd  <= r_tbl[w_grant].r;
                r_pkt.rs1 <= r_tbl[w_grant].r1;
                r_pkt.rs2 <= r_tbl[w_grant].r2;
                r_ptr     <= (w_grant == PTR_W'(NUM_FU - 1)) ? '0 : w_grant + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_err <= 1'b0;
        end else if (w_disp_err || w_wb_err) begin
            r_err <= 1'b1;
        end
    end

    assign disp_ready = ~w_busy;
    assign busy_o     = w_busy;
    assign iss_valid  = r_iss_valid;
    assign iss_fu     = r_pkt.fu;
    assign iss_rd     = r_pkt.rd;
    assign iss_rs1    = r_pkt.rs1;
    assign iss_rs2    = r_pkt.rs2;
    assign err        = r_err;

endmodule

`default_nettype wire
